// File: rtl/bit_sync_filter.sv
// Multi-channel level synchronizer with a per-channel stability filter.
// Emits registered single-cycle RISE/FALL strobes on accepted level changes.
module bit_sync_filter #(
  parameter int NUM_STAGES    = 2,
  parameter int BUS_WIDTH     = 4,
  parameter int FILTER_CYCLES = 3,
  parameter logic [BUS_WIDTH-1:0] RST_VAL = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] ASYNC,
  output logic [BUS_WIDTH-1:0] SYNC,
  output logic [BUS_WIDTH-1:0] RISE,
  output logic [BUS_WIDTH-1:0] FALL
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [BUS_WIDTH-1:0] chain [NUM_STAGES];
  logic [BUS_WIDTH-1:0] s_raw;
  logic [BUS_WIDTH-1:0] diff;
  logic [BUS_WIDTH-1:0] accept;
  logic [CW-1:0]        cnt [BUS_WIDTH];

  // Plain flop chain; nothing may sit between stages.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < NUM_STAGES; k++)
        chain[k] <= RST_VAL;
    end else begin
      chain[0] <= ASYNC;
      for (int k = 1; k < NUM_STAGES; k++)
        chain[k] <= chain[k-1];
    end
  end

  assign s_raw = chain[NUM_STAGES-1];
  assign diff  = s_raw ^ SYNC;

  always_comb begin
    accept = '0;
    for (int i = 0; i < BUS_WIDTH; i++)
      accept[i] = diff[i] && (cnt[i] == CNT_LAST);
  end

  // Any cycle of agreement clears the run of mismatches.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < BUS_WIDTH; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < BUS_WIDTH; i++) begin
        if (!diff[i] || accept[i])
          cnt[i] <= '0;
        else
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SYNC <= RST_VAL;
      RISE <= '0;
      FALL <= '0;
    end else begin
      SYNC <= (SYNC & ~accept) | (s_raw & accept);
      RISE <= accept & s_raw;
      FALL <= accept & ~s_raw;
    end
  end

endmodule

// File: tb/tb_bit_sync_filter.sv
// Directed table-driven bench for bit_sync_filter.
// Second instance covers the 3-stage, unfiltered, nonzero-reset configuration.
module tb_bit_sync_filter;

  typedef struct {
    logic       rst;
    logic [3:0] a;
    logic [3:0] s;
    logic [3:0] r;
    logic [3:0] f;
  } vec_t;

  logic       CLK = 0;
  logic       RST;
  logic [3:0] ASYNC;
  logic [3:0] SYNC, RISE, FALL;
  logic       RST2;
  logic [3:0] ASYNC2;
  logic [3:0] SYNC2, RISE2, FALL2;

  int total  = 0;
  int passed = 0;
  vec_t v[$];

  always #5 CLK = ~CLK;

  bit_sync_filter dut (
    .CLK(CLK), .RST(RST), .ASYNC(ASYNC),
    .SYNC(SYNC), .RISE(RISE), .FALL(FALL)
  );

  bit_sync_filter #(
    .NUM_STAGES(3), .BUS_WIDTH(4),
    .FILTER_CYCLES(1), .RST_VAL(4'hA)
  ) dut2 (
    .CLK(CLK), .RST(RST2), .ASYNC(ASYNC2),
    .SYNC(SYNC2), .RISE(RISE2), .FALL(FALL2)
  );

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic add(input logic rst, input logic [3:0] a,
                     input logic [3:0] s, input logic [3:0] r,
                     input logic [3:0] f, input int n);
    vec_t e;
    e.rst = rst; e.a = a; e.s = s; e.r = r; e.f = f;
    for (int k = 0; k < n; k++) v.push_back(e);
  endtask

  initial begin
    RST = 1; ASYNC = 4'hF;
    RST2 = 1; ASYNC2 = 4'hA;

    // reset with inputs high
    add(1, 4'hF, 4'h0, 4'h0, 4'h0, 2);
    // release, all channels rise after 5 edges
    add(0, 4'hF, 4'h0, 4'h0, 4'h0, 4);
    add(0, 4'hF, 4'hF, 4'hF, 4'h0, 1);
    add(0, 4'hF, 4'hF, 4'h0, 4'h0, 1);
    // all channels fall
    add(0, 4'h0, 4'hF, 4'h0, 4'h0, 4);
    add(0, 4'h0, 4'h0, 4'h0, 4'hF, 1);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    // 2-cycle glitch on ch0 rejected
    add(0, 4'h1, 4'h0, 4'h0, 4'h0, 2);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 6);
    // 3-cycle pulse on ch1 accepted, then falls
    add(0, 4'h2, 4'h0, 4'h0, 4'h0, 3);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    add(0, 4'h0, 4'h2, 4'h2, 4'h0, 1);
    add(0, 4'h0, 4'h2, 4'h0, 4'h0, 2);
    add(0, 4'h0, 4'h0, 4'h0, 4'h2, 1);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    // simultaneous rise/fall on different channels
    add(0, 4'h8, 4'h0, 4'h0, 4'h0, 4);
    add(0, 4'h8, 4'h8, 4'h8, 4'h0, 1);
    add(0, 4'h8, 4'h8, 4'h0, 4'h0, 1);
    add(0, 4'h4, 4'h8, 4'h0, 4'h0, 4);
    add(0, 4'h4, 4'h4, 4'h4, 4'h8, 1);
    add(0, 4'h4, 4'h4, 4'h0, 4'h0, 1);
    // reset while counters are at 2, then full latency again
    add(0, 4'hF, 4'h4, 4'h0, 4'h0, 4);
    add(1, 4'hF, 4'h0, 4'h0, 4'h0, 1);
    add(0, 4'hF, 4'h0, 4'h0, 4'h0, 4);
    add(0, 4'hF, 4'hF, 4'hF, 4'h0, 1);
    add(0, 4'hF, 4'hF, 4'h0, 4'h0, 1);

    for (int i = 0; i < v.size(); i++) begin
      @(negedge CLK);
      RST = v[i].rst;
      ASYNC = v[i].a;
      @(posedge CLK);
      #1;
      chk($sformatf("row%0d sync", i), SYNC, v[i].s);
      chk($sformatf("row%0d rise", i), RISE, v[i].r);
      chk($sformatf("row%0d fall", i), FALL, v[i].f);
    end

    // reset takes effect without a clock edge
    @(posedge CLK);
    #2 RST = 1;
    #1;
    chk("async_rst sync", SYNC, 4'h0);
    chk("async_rst rise", RISE, 4'h0);
    @(negedge CLK);
    RST = 0;
    ASYNC = 4'h0;

    // second instance: nonzero reset value, no filtering
    @(negedge CLK);
    chk("p2 rst sync", SYNC2, 4'hA);
    @(negedge CLK);
    RST2 = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("p2 hold%0d sync", k), SYNC2, 4'hA);
      chk($sformatf("p2 hold%0d rise", k), RISE2, 4'h0);
      chk($sformatf("p2 hold%0d fall", k), FALL2, 4'h0);
    end
    @(negedge CLK);
    ASYNC2 = 4'h5;
    for (int k = 1; k <= 5; k++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("p2 e%0d sync", k), SYNC2, (k >= 4) ? 4'h5 : 4'hA);
      chk($sformatf("p2 e%0d rise", k), RISE2, (k == 4) ? 4'h5 : 4'h0);
      chk($sformatf("p2 e%0d fall", k), FALL2, (k == 4) ? 4'hA : 4'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
